uart_imem_loader: RTL and testbench

Boot loader that sits directly upstream of the memory interface's instruction port. It receives a framed program image as a byte stream from the UART receiver and assembles little-endian 32-bit words. Each word is written as an aligned full-word store into instruction memory. The CPU is held via `cpu_hold` until a checksummed image has been loaded and acknowledged back over the UART transmitter.

---
 rtl/loader_pkg.sv | 26 ++
 rtl/byte_timeout.sv | 30 +++
 rtl/uart_imem_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_imem_loader.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package loader_pkg;

    // Frame-parser states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_RESP,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam logic [7:0] MAGIC      = 8'hA5;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;
    localparam logic [2:0] STORE_WORD = 3'b100;

    // Byte address of word idx relative to the image base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle timer: reloads on clr, counts down while en, flags expiry at zero.
module byte_timeout #(
    parameter int unsigned CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES);

    logic [CW-1:0] r_count;

    // Down-counter: reload on clr, otherwise decrement until it sticks at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= LOAD;
        end else if (clr) begin
            r_count <= LOAD;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign expired = (r_count == '0);

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: parses a framed image, writes little-endian words into
// instruction memory, verifies an 8-bit checksum and answers ACK/NAK.
module uart_imem_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        reload,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic [3:0]  imem_wen,
    output logic [2:0]  storecntrl_a,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [1:0]  r_byte_cnt;
    logic [23:0] r_asm;
    logic [7:0]  r_csum;
    logic        r_imem_en;
    logic [31:0] r_imem_addr;
    logic [31:0] r_imem_din;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_resp_ok;
    logic        r_load_done;
    logic        r_load_err;

    logic        w_start;
    logic        w_len_lo;
    logic        w_len_hi;
    logic        w_data_byte;
    logic        w_tx_load;
    logic [7:0]  w_tx_byte;
    logic        w_resp_ok;
    logic        w_hs_done;
    logic        w_active;
    logic        w_to_clr;
    logic        w_expired;
    logic [15:0] w_len_full;
    logic        w_len_too_big;
    logic [15:0] w_last_idx;

    assign w_active      = (r_state == ST_LEN0) || (r_state == ST_LEN1) ||
                           (r_state == ST_DATA) || (r_state == ST_CSUM);
    assign w_to_clr      = rx_valid || reload || !w_active;
    assign w_len_full    = {rx_data, r_len[7:0]};
    assign w_len_too_big = ({16'd0, w_len_full} > MAX_WORDS);
    assign w_last_idx    = r_len - 16'd1;

    byte_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (w_to_clr),
        .en      (w_active),
        .expired (w_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle datapath strobes; reload overrides everything
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_len_lo    = 1'b0;
        w_len_hi    = 1'b0;
        w_data_byte = 1'b0;
        w_tx_load   = 1'b0;
        w_tx_byte   = NAK_BYTE;
        w_resp_ok   = 1'b0;
        w_hs_done   = 1'b0;
        if (reload) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (rx_valid && (rx_data == MAGIC)) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_LEN0;
                    end
                end
                ST_LEN0: begin
                    if (rx_valid) begin
                        w_len_lo    = 1'b1;
                        w_state_nxt = ST_LEN1;
                    end else if (w_expired) begin
                        w_tx_load   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
                ST_LEN1: begin
                    if (rx_valid) begin
                        w_len_hi = 1'b1;
                        if (w_len_full == 16'd0) begin
                            w_state_nxt = ST_CSUM;
                        end else if (w_len_too_big) begin
                            w_tx_load   = 1'b1;
                            w_state_nxt = ST_RESP;
                        end else begin
                            w_state_nxt = ST_DATA;
                        end
                    end else if (w_expired) begin
                        w_tx_load   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        w_data_byte = 1'b1;
                        if ((r_byte_cnt == 2'd3) && (r_idx == w_last_idx)) begin
                            w_state_nxt = ST_CSUM;
                        end
                    end else if (w_expired) begin
                        w_tx_load   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        w_tx_load = 1'b1;
                        if (rx_data == r_csum) begin
                            w_tx_byte = ACK_BYTE;
                            w_resp_ok = 1'b1;
                        end
                        w_state_nxt = ST_RESP;
                    end else if (w_expired) begin
                        w_tx_load   = 1'b1;
                        w_state_nxt = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_tx_valid && tx_ready) begin
                        w_hs_done   = 1'b1;
                        w_state_nxt = r_resp_ok ? ST_DONE : ST_ERR;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Word assembler, write port, checksum, response register and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_byte_cnt  <= '0;
            r_asm       <= '0;
            r_csum      <= '0;
            r_imem_en   <= 1'b0;
            r_imem_addr <= '0;
            r_imem_din  <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
            r_resp_ok   <= 1'b0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_imem_en <= 1'b0;
            if (reload) begin
                r_tx_valid  <= 1'b0;
                r_load_done <= 1'b0;
                r_load_err  <= 1'b0;
            end else begin
                if (w_start) begin
                    r_idx       <= '0;
                    r_byte_cnt  <= '0;
                    r_csum      <= '0;
                    r_load_done <= 1'b0;
                    r_load_err  <= 1'b0;
                end
                if (w_len_lo) begin
                    r_len[7:0] <= rx_data;
                end
                if (w_len_hi) begin
                    r_len[15:8] <= rx_data;
                end
                if (w_data_byte) begin
                    r_csum     <= r_csum + rx_data;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        // Fourth byte completes the word: strobe it out next cycle
                        r_imem_en   <= 1'b1;
                        r_imem_din  <= {rx_data, r_asm};
                        r_imem_addr <= word_addr(BASE_ADDR, r_idx);
                        r_idx       <= r_idx + 16'd1;
                    end else begin
                        r_asm <= {rx_data, r_asm[23:8]};
                    end
                end
                if (w_tx_load) begin
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= w_tx_byte;
                    r_resp_ok  <= w_resp_ok;
                end
                if (w_hs_done) begin
                    r_tx_valid  <= 1'b0;
                    r_load_done <= r_resp_ok;
                    r_load_err  <= !r_resp_ok;
                end
            end
        end
    end

    assign imem_en      = r_imem_en;
    assign imem_addr    = r_imem_addr;
    assign imem_din     = r_imem_din;
    assign imem_wen     = r_imem_en ? 4'b1111 : 4'b0000;
    assign storecntrl_a = r_imem_en ? STORE_WORD : 3'b000;
    assign tx_valid     = r_tx_valid;
    assign tx_data      = r_tx_data;
    assign cpu_hold     = (r_state != ST_DONE);
    assign load_done    = r_load_done;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: vector table of frames with random
// payloads, a frame-level reference model, and hand-written corner sequences.
module tb_uart_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          MAXW = 2048;
    localparam int          TO   = 40;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NAK  = 8'h15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        reload;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic [3:0]  imem_wen;
    logic [2:0]  storecntrl_a;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int         n;
        bit         bad;
        int         gapmax;
        int         rdy;
        logic [7:0] exp_tx;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    wr_t  exp_q[$];
    wr_t  mon_e;
    int   checks = 0;
    int   errors = 0;
    int   wr_count = 0;
    logic expect_wr = 1'b0;
    logic exp_now = 1'b0;

    uart_imem_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .reload       (reload),
        .imem_en      (imem_en),
        .imem_addr    (imem_addr),
        .imem_din     (imem_din),
        .imem_wen     (imem_wen),
        .storecntrl_a (storecntrl_a),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // A write is expected exactly in the cycle after a word-completing byte is sampled
    always @(posedge clk) begin
        if (!rst_n) exp_now <= 1'b0;
        else        exp_now <= rx_valid && expect_wr && !reload;
    end

    always @(negedge clk) begin
        if (rst_n && (exp_now || imem_en)) begin
            check("wr_strobe", 32'(imem_en), 32'(exp_now));
            if (imem_en) begin
                wr_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected actual addr=%h data=%h required none", imem_addr, imem_din);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_addr", imem_addr, mon_e.addr);
                    check("wr_data", imem_din, mon_e.data);
                    check("wr_ctl", 32'({imem_wen, storecntrl_a}), 32'({4'b1111, 3'b100}));
                end
            end
        end
    end

    // Drive one byte for one cycle (entered and left on a negedge), then idle gap cycles
    task automatic send_byte(input logic [7:0] b, input logic wr, input int gap);
        rx_valid  = 1'b1;
        rx_data   = b;
        expect_wr = wr;
        @(negedge clk);
        rx_valid  = 1'b0;
        expect_wr = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        @(negedge clk);
    endtask

    // Observe the pending response, stall tx_ready for rdy cycles, then complete the handshake
    task automatic finish_resp(input logic [7:0] exp_tx, input int rdy, input bit done, input bit err);
        logic [7:0] d;
        bit stable;
        check("tx_rise", 32'(tx_valid), 32'd1);
        check("tx_byte", 32'(tx_data), 32'(exp_tx));
        check("hold_busy", 32'(cpu_hold), 32'd1);
        d = tx_data;
        stable = 1'b1;
        repeat (rdy) begin
            @(negedge clk);
            if (tx_valid !== 1'b1 || tx_data !== d || cpu_hold !== 1'b1) stable = 1'b0;
        end
        if (rdy > 0) check("tx_stable", 32'(stable), 32'd1);
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        check("tx_drop", 32'(tx_valid), 32'd0);
        check("hold_after", 32'(cpu_hold), 32'(!done));
        check("flags", 32'({load_done, load_err}), 32'({done, err}));
        @(negedge clk);
    endtask

    // Reference model: build the frame from its definition and queue the expected writes
    task automatic run_frame(input vec_t v);
        logic [15:0] len;
        logic [31:0] word;
        logic [7:0]  sum;
        logic [7:0]  b;
        int wc0, nwr;
        wc0 = wr_count;
        nwr = 0;
        sum = 8'h00;
        len = v.n[15:0];
        send_byte(8'hA5, 1'b0, $urandom_range(0, v.gapmax));
        send_byte(len[7:0], 1'b0, $urandom_range(0, v.gapmax));
        if (v.n > MAXW) begin
            send_byte(len[15:8], 1'b0, 0);
        end else begin
            send_byte(len[15:8], 1'b0, $urandom_range(0, v.gapmax));
            for (int w = 0; w < v.n; w++) begin
                word = $urandom;
                exp_q.push_back('{BASE + 32'(4 * w), word});
                nwr++;
                for (int k = 0; k < 4; k++) begin
                    b = word[8*k +: 8];
                    sum = sum + b;
                    send_byte(b, k == 3, $urandom_range(0, v.gapmax));
                end
            end
            send_byte(v.bad ? (sum + 8'h5A) : sum, 1'b0, 0);
        end
        finish_resp(v.exp_tx, v.rdy, v.exp_done, v.exp_err);
        check("frame_wr_cnt", 32'(wr_count - wc0), 32'(nwr));
        check("frame_q_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_ctl"}, 32'({tx_valid, imem_en, imem_wen, storecntrl_a, load_done, load_err}), 32'd0);
        check({tag, "_tx"}, 32'(tx_data), 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_din"}, imem_din, 32'd0);
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        logic [7:0] b;
        int wc0, k;
        bit tohit;

        tbl[0] = '{3,    1'b0, 0, 0,  ACK, 1'b1, 1'b0};
        tbl[1] = '{5,    1'b0, 3, 1,  ACK, 1'b1, 1'b0};
        tbl[2] = '{2,    1'b1, 2, 0,  NAK, 1'b0, 1'b1};
        tbl[3] = '{0,    1'b0, 1, 0,  ACK, 1'b1, 1'b0};
        tbl[4] = '{2049, 1'b0, 0, 3,  NAK, 1'b0, 1'b1};
        tbl[5] = '{8,    1'b0, 2, 10, ACK, 1'b1, 1'b0};
        tbl[6] = '{1,    1'b1, 0, 0,  NAK, 1'b0, 1'b1};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        reload   = 1'b0;
        #1;
        check_reset_outs("rst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Noise before MAGIC is discarded
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(0, 255));
            while (b == 8'hA5) b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b0, $urandom_range(0, 2));
        end
        check("noise_idle", 32'({cpu_hold, tx_valid}), 32'({1'b1, 1'b0}));

        // Reference frame A5 01 00 78 56 34 12 14
        wc0 = wr_count;
        exp_q.push_back('{32'h0, 32'h1234_5678});
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h78, 1'b0, 0);
        send_byte(8'h56, 1'b0, 0);
        send_byte(8'h34, 1'b0, 0);
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h14, 1'b0, 0);
        finish_resp(ACK, 2, 1'b1, 1'b0);
        check("spec_wr_cnt", 32'(wr_count - wc0), 32'd1);

        // Vector table: reload between frames
        for (int i = 0; i < 7; i++) begin
            pulse_reload();
            run_frame(tbl[i]);
        end

        // Bad checksum, then a good frame straight from ERR
        pulse_reload();
        run_frame('{2, 1'b1, 1, 0, NAK, 1'b0, 1'b1});
        run_frame('{2, 1'b0, 1, 0, ACK, 1'b1, 1'b0});

        // DONE ignores bytes, including MAGIC
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h01, 1'b0, 2);
        check("done_ignores", 32'({cpu_hold, load_done, tx_valid}), 32'({1'b0, 1'b1, 1'b0}));

        // Inter-byte timeout mid-DATA
        pulse_reload();
        wc0 = wr_count;
        exp_q.push_back('{BASE, 32'hCAFE_F00D});
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h0D, 1'b0, 0);
        send_byte(8'hF0, 1'b0, 0);
        send_byte(8'hFE, 1'b0, 0);
        send_byte(8'hCA, 1'b1, 0);
        send_byte(8'h11, 1'b0, 0);
        k = 0;
        while (tx_valid !== 1'b1 && k < TO + 20) begin
            @(negedge clk);
            k++;
        end
        tohit = (k >= TO) && (k <= TO + 2);
        checks++;
        if (!tohit) begin
            errors++;
            $display("FAIL to_latency actual=%0d cycles required=%0d..%0d", k, TO, TO + 2);
        end
        finish_resp(NAK, 10, 1'b0, 1'b1);
        check("to_wr_cnt", 32'(wr_count - wc0), 32'd1);

        // reload together with a word-completing rx_valid
        pulse_reload();
        wc0 = wr_count;
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        reload = 1'b1;
        send_byte(8'h04, 1'b0, 0);
        reload = 1'b0;
        @(negedge clk);
        check("rl_no_wr", 32'(wr_count - wc0), 32'd0);
        check("rl_state", 32'({cpu_hold, tx_valid, load_done, load_err}), 32'({1'b1, 1'b0, 1'b0, 1'b0}));
        run_frame('{1, 1'b0, 0, 0, ACK, 1'b1, 1'b0});

        // reload while a response is pending
        pulse_reload();
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h08, 1'b0, 0);
        check("rl_tx_pend", 32'({tx_valid, tx_data}), 32'({1'b1, NAK}));
        tx_ready = 1'b1;
        reload   = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        reload   = 1'b0;
        check("rl_tx_drop", 32'({tx_valid, cpu_hold, load_done, load_err}), 32'({1'b0, 1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        run_frame('{2, 1'b0, 1, 0, ACK, 1'b1, 1'b0});

        // Asynchronous reset while in DONE: outputs drop immediately
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("arst_done");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Asynchronous reset mid-frame after one word was written
        wc0 = wr_count;
        exp_q.push_back('{BASE, 32'h4433_2211});
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h03, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h22, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h44, 1'b1, 0);
        send_byte(8'h55, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outs("arst_mid");
        check("arst_mid_wr", 32'(wr_count - wc0), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame('{3, 1'b0, 2, 1, ACK, 1'b1, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
